// File: rtl/rf_wb_scoreboard.sv
// Register-file scoreboard: per-register busy tracking with RAW/WAW issue holds,
// plus round-robin arbitration of two writeback sources onto the single RF write port.
module rf_wb_scoreboard #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    input  logic            issue_wen,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_rd,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [AW-1:0]   b_rd,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [NREG-1:0] busy_mask,
    output logic            wb_err
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            last_grant_b_q;
    logic            grant_a;
    logic            grant_b;
    logic            accept;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            hazard;
    logic            issue_fire;

    // Hazard check looks only at registered busy bits; a same-cycle commit is not bypassed.
    always_comb begin
        hazard = 1'b0;
        if ((issue_rs1 != '0) && busy_q[issue_rs1])
            hazard = 1'b1;
        if ((issue_rs2 != '0) && busy_q[issue_rs2])
            hazard = 1'b1;
        if (issue_wen && (issue_rd != '0) && busy_q[issue_rd])
            hazard = 1'b1;
    end

    assign issue_ready = ~hazard;
    assign issue_fire  = issue_valid & issue_ready & issue_wen & (issue_rd != '0);

    // Round-robin: on contention the source that did not win last time is granted.
    assign grant_a = a_valid & (~b_valid | last_grant_b_q);
    assign grant_b = b_valid & (~a_valid | ~last_grant_b_q);
    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign accept  = grant_a | grant_b;

    always_comb begin
        sel_rd   = b_rd;
        sel_data = b_data;
        if (grant_a) begin
            sel_rd   = a_rd;
            sel_data = a_data;
        end
    end

    // Commit clears first, then a new issue sets, so a set would win on a collision.
    always_comb begin
        busy_d = busy_q;
        if (rf_wen)
            busy_d[rf_waddr] = 1'b0;
        if (issue_fire)
            busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q         <= '0;
            last_grant_b_q <= 1'b1;
            rf_wen         <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            wb_err         <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (a_valid && b_valid)
                last_grant_b_q <= grant_b;
            rf_wen <= accept && (sel_rd != '0);
            if (accept) begin
                rf_waddr <= sel_rd;
                rf_wdata <= sel_data;
            end
            if (rf_wen && !busy_q[rf_waddr])
                wb_err <= 1'b1;
        end
    end

    assign busy_mask = {busy_q[NREG-1:1], 1'b0};

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Directed vector table plus a hand-written WAW sequence for rf_wb_scoreboard.
module tb_rf_wb_scoreboard;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            issue_valid;
    logic [AW-1:0]   issue_rs1;
    logic [AW-1:0]   issue_rs2;
    logic            issue_wen;
    logic [AW-1:0]   issue_rd;
    logic            issue_ready;
    logic            a_valid;
    logic [AW-1:0]   a_rd;
    logic [XLEN-1:0] a_data;
    logic            a_ready;
    logic            b_valid;
    logic [AW-1:0]   b_rd;
    logic [XLEN-1:0] b_data;
    logic            b_ready;
    logic            rf_wen;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [NREG-1:0] busy_mask;
    logic            wb_err;

    int n_checks = 0;
    int n_fail   = 0;

    rf_wb_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_wen(issue_wen), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_mask(busy_mask), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic            iv;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic            iw;
        logic [AW-1:0]   rd;
        logic            av;
        logic [AW-1:0]   ard;
        logic [XLEN-1:0] ad;
        logic            bv;
        logic [AW-1:0]   brd;
        logic [XLEN-1:0] bd;
        logic            e_ir;
        logic            e_ar;
        logic            e_br;
        logic            e_wen;
        logic [AW-1:0]   e_wa;
        logic [XLEN-1:0] e_wd;
        logic [NREG-1:0] e_busy;
        logic            e_err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input int r, input int iv, input int rs1, input int rs2,
                                input int iw, input int rd, input int av, input int ard,
                                input logic [63:0] ad, input int bv, input int brd,
                                input logic [63:0] bd, input int ir, input int ar,
                                input int br, input int wen, input int wa,
                                input logic [63:0] wd, input logic [31:0] busy,
                                input int err);
        vec_t t;
        t.rst = 1'(r);    t.iv = 1'(iv);    t.rs1 = AW'(rs1); t.rs2 = AW'(rs2);
        t.iw = 1'(iw);    t.rd = AW'(rd);   t.av = 1'(av);    t.ard = AW'(ard);
        t.ad = ad;        t.bv = 1'(bv);    t.brd = AW'(brd); t.bd = bd;
        t.e_ir = 1'(ir);  t.e_ar = 1'(ar);  t.e_br = 1'(br);  t.e_wen = 1'(wen);
        t.e_wa = AW'(wa); t.e_wd = wd;      t.e_busy = busy;  t.e_err = 1'(err);
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0;
        issue_wen = 1'b0; issue_rd = '0; a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
    endtask

    initial begin
        int commit_k;
        int fire_k;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        //            rst iv r1 r2 iw rd  av ard ad       bv brd bd      ir ar br wen wa wd       busy   err
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 0, 0, 64'h0,    32'h0,  0));
        vq.push_back(mk(0, 1, 0, 0, 1, 5,  0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 0, 0, 64'h0,    32'h0,  0));
        vq.push_back(mk(0, 1, 5, 0, 0, 0,  0, 0, 64'h0,   0, 0, 64'h0,   0, 0, 0, 0, 0, 64'h0,    32'h20, 0));
        vq.push_back(mk(0, 1, 5, 0, 0, 0,  1, 5, 64'h55,  0, 0, 64'h0,   0, 1, 0, 0, 0, 64'h0,    32'h20, 0));
        vq.push_back(mk(0, 1, 5, 0, 0, 0,  0, 0, 64'h0,   0, 0, 64'h0,   0, 0, 0, 1, 5, 64'h55,   32'h20, 0));
        vq.push_back(mk(0, 1, 5, 0, 0, 0,  0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 0, 5, 64'h55,   32'h0,  0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 0, 5, 64'h55,   32'h0,  0));
        // contention A rd=1 vs B rd=2, A first after reset
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 64'hA1,  1, 2, 64'hB2,  1, 1, 0, 0, 0, 64'h0,    32'h0,  0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 64'hA1,  1, 2, 64'hB2,  1, 0, 1, 1, 1, 64'hA1,   32'h0,  0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 64'hA1,  1, 2, 64'hB2,  1, 1, 0, 1, 2, 64'hB2,   32'h0,  1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 64'hA1,  1, 2, 64'hB2,  1, 0, 1, 1, 1, 64'hA1,   32'h0,  1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 1, 2, 64'hB2,   32'h0,  1));
        vq.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 0, 2, 64'hB2,   32'h0,  1));
        // rd=0 beat accepted and dropped
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 64'hDEAD,0, 0, 64'h0,   1, 1, 0, 0, 0, 64'h0,    32'h0,  0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 0, 0, 64'hDEAD, 32'h0,  0));
        // commit to non-busy x9 -> sticky wb_err
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  1, 9, 64'h99,  0, 0, 64'h0,   1, 1, 0, 0, 0, 64'hDEAD, 32'h0,  0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 1, 9, 64'h99,   32'h0,  0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 0, 9, 64'h99,   32'h0,  1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 0, 9, 64'h99,   32'h0,  1));
        vq.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 0, 9, 64'h99,   32'h0,  1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 0, 0, 64'h0,    32'h0,  0));
        // x0 never busy; rs2 hazard; rd ignored when wen=0; WAW on x3
        vq.push_back(mk(0, 1, 0, 0, 1, 0,  0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 0, 0, 64'h0,    32'h0,  0));
        vq.push_back(mk(0, 1, 0, 0, 1, 3,  0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 0, 0, 64'h0,    32'h0,  0));
        vq.push_back(mk(0, 1, 0, 3, 0, 0,  0, 0, 64'h0,   0, 0, 64'h0,   0, 0, 0, 0, 0, 64'h0,    32'h8,  0));
        vq.push_back(mk(0, 1, 0, 0, 0, 3,  0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 0, 0, 64'h0,    32'h8,  0));
        vq.push_back(mk(0, 1, 0, 0, 1, 3,  0, 0, 64'h0,   0, 0, 64'h0,   0, 0, 0, 0, 0, 64'h0,    32'h8,  0));
        // beat to busy x3 accepted in the reset cycle is discarded
        vq.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 64'h0,   1, 3, 64'h33,  1, 0, 1, 0, 0, 64'h0,    32'h8,  0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 0, 0, 64'h0,    32'h0,  0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 0, 0, 64'h0,    32'h0,  0));

        foreach (vq[i]) begin
            @(posedge clk);
            #1;
            rst = vq[i].rst; issue_valid = vq[i].iv; issue_rs1 = vq[i].rs1;
            issue_rs2 = vq[i].rs2; issue_wen = vq[i].iw; issue_rd = vq[i].rd;
            a_valid = vq[i].av; a_rd = vq[i].ard; a_data = vq[i].ad;
            b_valid = vq[i].bv; b_rd = vq[i].brd; b_data = vq[i].bd;
            @(negedge clk);
            chk($sformatf("v%0d.issue_ready", i), 64'(issue_ready), 64'(vq[i].e_ir));
            chk($sformatf("v%0d.a_ready", i),     64'(a_ready),     64'(vq[i].e_ar));
            chk($sformatf("v%0d.b_ready", i),     64'(b_ready),     64'(vq[i].e_br));
            chk($sformatf("v%0d.rf_wen", i),      64'(rf_wen),      64'(vq[i].e_wen));
            chk($sformatf("v%0d.rf_waddr", i),    64'(rf_waddr),    64'(vq[i].e_wa));
            chk($sformatf("v%0d.rf_wdata", i),    rf_wdata,         vq[i].e_wd);
            chk($sformatf("v%0d.busy_mask", i),   64'(busy_mask),   64'(vq[i].e_busy));
            chk($sformatf("v%0d.wb_err", i),      64'(wb_err),      64'(vq[i].e_err));
        end

        // WAW on x7: second issue held until B commits, fires the cycle after the commit
        @(posedge clk); #1;
        idle_inputs();
        issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd7;
        @(negedge clk);
        chk("waw_first_ready", 64'(issue_ready), 64'd1);
        @(posedge clk); #1;
        b_valid = 1'b1; b_rd = 5'd7; b_data = 64'h77;
        @(negedge clk);
        chk("waw_second_blocked", 64'(issue_ready), 64'd0);
        chk("waw_b_ready", 64'(b_ready), 64'd1);
        chk("waw_busy_x7", 64'(busy_mask), 64'h80);
        @(posedge clk); #1;
        b_valid = 1'b0;
        commit_k = -1;
        fire_k = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rf_wen && commit_k < 0) commit_k = k;
            if (issue_ready) begin
                fire_k = k;
                break;
            end
            @(posedge clk); #1;
        end
        chk("waw_commit_cycle", 64'(commit_k), 64'(0));
        chk("waw_fire_cycle", 64'(fire_k), 64'(commit_k + 1));
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("waw_reissue_busy", 64'(busy_mask), 64'h80);
        chk("waw_no_err", 64'(wb_err), 64'd0);
        chk("waw_commit_data", rf_wdata, 64'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
